osd_dii_reg_initiator: RTL and testbench

Register-access initiator for the debug interconnect: accepts single 16-bit register read/write commands from a local master (debug coprocessor, host bridge), serializes them into DII request packets toward a remote module, and parses the matching response packet. It is the requesting end of the register-access protocol that the per-module register-access responders answer. It sits between a local command port and a debug-ring port pair (`debug_out` / `debug_in`).

---
 rtl/osd_dii_reg_initiator.sv | 247 ++++++++++++++++++++++++
 tb/tb_osd_dii_reg_initiator.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_dii_reg_initiator.sv
// ---------------------------------------------------------------------------
// osd_dii_reg_initiator
//
// Requesting end of the debug register-access protocol. A local master hands
// over one 16-bit register read or write at a time. The block serializes it
// into a DII request packet on debug_out, then waits for the matching
// response packet on debug_in and reports completion with a one-cycle
// resp_valid pulse.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   id                own 10-bit module address, sent as the source field
//   req_*             command handshake (valid/ready) plus write, dest, addr,
//                     wdata
//   resp_*            completion pulse with error, timeout and read data
//   debug_out(_ready) request flit stream toward the ring
//   debug_in(_ready)  response flit stream from the ring
// ---------------------------------------------------------------------------
package osd_dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module osd_dii_reg_initiator
    import osd_dii_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  id,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_dest,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic        resp_timeout,
    output logic [15:0] resp_rdata,
    output dii_flit     debug_out,
    input  logic        debug_out_ready,
    input  dii_flit     debug_in,
    output logic        debug_in_ready
);

    localparam logic [3:0]  SUB_RD_REQ = 4'b0000;
    localparam logic [3:0]  SUB_WR_REQ = 4'b0100;
    localparam logic [3:0]  SUB_RD_OK  = 4'b1000;
    localparam logic [3:0]  SUB_RD_ERR = 4'b1100;
    localparam logic [3:0]  SUB_WR_OK  = 4'b1110;
    localparam logic [3:0]  SUB_WR_ERR = 4'b1111;
    localparam bit          TMO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, DRAIN, RESP} state_e;

    state_e      state_q, state_d;
    logic        write_q;
    logic [15:0] dest_q, addr_q, wdata_q;
    logic [2:0]  flitCnt_q, flitCnt_d;
    logic [2:0]  rxCnt_q, rxCnt_d;
    logic        srcOk_q, srcOk_d;
    logic [5:0]  flags_q, flags_d;
    logic [31:0] tmoCnt_q, tmoCnt_d;
    logic        reqReady_q, inReady_q;
    logic        respErr_q, respErr_d;
    logic        respTimeout_q, respTimeout_d;
    logic [15:0] respRdata_q, respRdata_d;

    logic [5:0]  curFlags;
    logic [3:0]  succCode, errCode;
    logic        isErr, isReadOk, isMatch, lenOk;
    logic        inFire, outFire, reqFire, respDone, expired;
    logic [2:0]  lastIdx;

    // Decode of the packet currently being received. The flags word only
    // becomes final on flit 2, so a 3-flit packet whose last flit is the
    // flags word is judged from the live bus rather than the stored copy.
    always_comb begin
        curFlags = (rxCnt_q == 3'd2) ? debug_in.data[15:10] : flags_q;
        succCode = write_q ? SUB_WR_OK  : SUB_RD_OK;
        errCode  = write_q ? SUB_WR_ERR : SUB_RD_ERR;
        isErr    = (curFlags[3:0] == errCode);
        isReadOk = !write_q && (curFlags[3:0] == SUB_RD_OK);
        isMatch  = srcOk_q && (curFlags[5:4] == 2'b00) &&
                   ((curFlags[3:0] == succCode) || isErr);
        lenOk    = isReadOk ? (rxCnt_q == 3'd3) : (rxCnt_q == 3'd2);
        inFire   = debug_in.valid && inReady_q;
        outFire  = (state_q == SEND) && debug_out_ready;
        reqFire  = (state_q == IDLE) && req_valid && reqReady_q;
        lastIdx  = write_q ? 3'd4 : 3'd3;
        respDone = (state_q == WAIT) && inFire && debug_in.last && isMatch && lenOk;
        expired  = TMO_EN && (tmoCnt_q == TMO_LAST);
    end

    // Next-state logic. The receive counter tracks packet position in every
    // state that sinks flits, so a packet that started arriving earlier is
    // still indexed correctly; it saturates so over-long packets never alias
    // onto a valid length.
    always_comb begin
        state_d       = state_q;
        flitCnt_d     = flitCnt_q;
        rxCnt_d       = rxCnt_q;
        srcOk_d       = srcOk_q;
        flags_d       = flags_q;
        tmoCnt_d      = tmoCnt_q;
        respErr_d     = respErr_q;
        respTimeout_d = respTimeout_q;
        respRdata_d   = respRdata_q;

        if (inFire) begin
            if (debug_in.last) begin
                rxCnt_d = 3'd0;
            end else if (rxCnt_q != 3'd7) begin
                rxCnt_d = rxCnt_q + 3'd1;
            end
            if (rxCnt_q == 3'd1) begin
                srcOk_d = (debug_in.data == dest_q);
            end
            if (rxCnt_q == 3'd2) begin
                flags_d = debug_in.data[15:10];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (reqFire) begin
                    state_d   = SEND;
                    flitCnt_d = 3'd0;
                end
            end
            SEND: begin
                if (outFire) begin
                    if (flitCnt_q == lastIdx) begin
                        state_d  = WAIT;
                        tmoCnt_d = 32'd0;
                    end else begin
                        flitCnt_d = flitCnt_q + 3'd1;
                    end
                end
            end
            WAIT: begin
                tmoCnt_d = tmoCnt_q + 32'd1;
                if (respDone) begin
                    state_d       = RESP;
                    respErr_d     = isErr;
                    respTimeout_d = 1'b0;
                    respRdata_d   = isReadOk ? debug_in.data : 16'h0000;
                end else if (expired) begin
                    if (rxCnt_d != 3'd0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d       = RESP;
                        respErr_d     = 1'b1;
                        respTimeout_d = 1'b1;
                        respRdata_d   = 16'h0000;
                    end
                end
            end
            DRAIN: begin
                if (inFire && debug_in.last) begin
                    state_d       = RESP;
                    respErr_d     = 1'b1;
                    respTimeout_d = 1'b1;
                    respRdata_d   = 16'h0000;
                end
            end
            RESP: begin
                state_d       = IDLE;
                respErr_d     = 1'b0;
                respTimeout_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Both ready outputs are registered from
    // the next state so neither depends combinationally on debug_in, and
    // req_ready stays low for the whole reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            dest_q        <= 16'h0000;
            addr_q        <= 16'h0000;
            wdata_q       <= 16'h0000;
            flitCnt_q     <= 3'd0;
            rxCnt_q       <= 3'd0;
            srcOk_q       <= 1'b0;
            flags_q       <= 6'd0;
            tmoCnt_q      <= 32'd0;
            reqReady_q    <= 1'b0;
            inReady_q     <= 1'b0;
            respErr_q     <= 1'b0;
            respTimeout_q <= 1'b0;
            respRdata_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            flitCnt_q     <= flitCnt_d;
            rxCnt_q       <= rxCnt_d;
            srcOk_q       <= srcOk_d;
            flags_q       <= flags_d;
            tmoCnt_q      <= tmoCnt_d;
            reqReady_q    <= (state_d == IDLE);
            inReady_q     <= (state_d == IDLE) || (state_d == WAIT) || (state_d == DRAIN);
            respErr_q     <= respErr_d;
            respTimeout_q <= respTimeout_d;
            respRdata_q   <= respRdata_d;
            if (reqFire) begin
                write_q <= req_write;
                dest_q  <= req_dest;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Request flit mux; driven only from registers so it holds steady while
    // the downstream stalls.
    always_comb begin
        debug_out = '0;
        if (state_q == SEND) begin
            debug_out.valid = 1'b1;
            debug_out.last  = (flitCnt_q == lastIdx);
            unique case (flitCnt_q)
                3'd0:    debug_out.data = dest_q;
                3'd1:    debug_out.data = {6'b0, id};
                3'd2:    debug_out.data = {2'b00, (write_q ? SUB_WR_REQ : SUB_RD_REQ), 10'b0};
                3'd3:    debug_out.data = addr_q;
                default: debug_out.data = wdata_q;
            endcase
        end
    end

    assign req_ready      = reqReady_q;
    assign debug_in_ready = inReady_q;
    assign resp_valid     = (state_q == RESP);
    assign resp_err       = respErr_q;
    assign resp_timeout   = respTimeout_q;
    assign resp_rdata     = respRdata_q;

endmodule

// File: tb/tb_osd_dii_reg_initiator.sv
// ---------------------------------------------------------------------------
// tb_osd_dii_reg_initiator
//
// Drives register commands into osd_dii_reg_initiator, checks the request
// flits it emits, feeds scheduled response packets back and compares the
// completion against a packet-level reference model.
// ---------------------------------------------------------------------------
module tb_osd_dii_reg_initiator;
    import osd_dii_pkg::*;

    localparam int TMO     = 16;
    localparam int SCH_MAX = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  id;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_dest, req_addr, req_wdata;
    logic        resp_valid, resp_err, resp_timeout;
    logic [15:0] resp_rdata;
    dii_flit     debug_out, debug_in;
    logic        debug_out_ready, debug_in_ready;

    int checks = 0;
    int errors = 0;

    // Response schedule: one slot per cycle after the request has gone out
    logic        schValid [SCH_MAX];
    logic [15:0] schData  [SCH_MAX];
    logic        schLast  [SCH_MAX];
    int          schLen;

    always #5 clk = ~clk;

    osd_dii_reg_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_dest        (req_dest),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .resp_timeout    (resp_timeout),
        .resp_rdata      (resp_rdata),
        .debug_out       (debug_out),
        .debug_out_ready (debug_out_ready),
        .debug_in        (debug_in),
        .debug_in_ready  (debug_in_ready)
    );

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearSched();
        for (int i = 0; i < SCH_MAX; i++) begin
            schValid[i] = 1'b0;
            schData[i]  = 16'h0000;
            schLast[i]  = 1'b0;
        end
        schLen = 0;
    endtask

    task automatic addFlit(input int gap, input logic [15:0] data, input logic last);
        schLen += gap;
        if (schLen < SCH_MAX) begin
            schValid[schLen] = 1'b1;
            schData[schLen]  = data;
            schLast[schLen]  = last;
            schLen++;
        end
    endtask

    // kind: 0 good success, 1 good error, 2 foreign source, 3 wrong TYPE,
    // 4 subtype of the other operation, 5 success with wrong length
    task automatic addPacket(input int kind, input logic wr, input logic [15:0] dest, input int maxGap);
        logic [15:0] src, flags, okFlags, word;
        int n;
        okFlags = wr ? 16'h3800 : 16'h2000;
        src     = dest;
        flags   = okFlags;
        n       = wr ? 3 : 4;
        case (kind)
            1: begin flags = wr ? 16'h3C00 : 16'h3000; n = 3; end
            2: src = dest ^ 16'h0004;
            3: flags = okFlags | 16'h4000;
            4: begin flags = wr ? 16'h2000 : 16'h3800; n = wr ? 4 : 3; end
            5: n = wr ? 4 : 3;
            default: ;
        endcase
        for (int i = 0; i < n; i++) begin
            if (i == 0)      word = {6'b0, id};
            else if (i == 1) word = src;
            else if (i == 2) word = flags;
            else             word = 16'($urandom);
            addFlit(int'($urandom_range(maxGap, 0)), word, i == n - 1);
        end
    endtask

    // Reference model: walks the schedule packet by packet and decides when
    // and how the command completes, including timeout and drain.
    task automatic predict(input logic wr, input logic [15:0] dest, output int respCycle,
                           output logic eErr, output logic eTmo, output logic [15:0] eRd);
        logic [15:0] pkt[$];
        logic [15:0] f;
        logic [3:0]  okSub, errSub;
        bit          draining;
        draining  = 0;
        respCycle = -1;
        eErr = 1'b0; eTmo = 1'b0; eRd = 16'h0000;
        okSub  = wr ? 4'b1110 : 4'b1000;
        errSub = wr ? 4'b1111 : 4'b1100;
        for (int c = 0; c < SCH_MAX + TMO && respCycle < 0; c++) begin
            if (c < SCH_MAX && schValid[c]) begin
                pkt.push_back(schData[c]);
                if (schLast[c]) begin
                    if (draining) begin
                        respCycle = c + 1; eErr = 1'b1; eTmo = 1'b1; eRd = 16'h0000;
                    end else if (pkt.size() >= 3 && pkt[1] == dest) begin
                        f = pkt[2];
                        if (f[15:14] == 2'b00) begin
                            if (f[13:10] == okSub && !wr && pkt.size() == 4) begin
                                respCycle = c + 1; eErr = 1'b0; eRd = pkt[3];
                            end else if (f[13:10] == okSub && wr && pkt.size() == 3) begin
                                respCycle = c + 1; eErr = 1'b0; eRd = 16'h0000;
                            end else if (f[13:10] == errSub && pkt.size() == 3) begin
                                respCycle = c + 1; eErr = 1'b1; eRd = 16'h0000;
                            end
                        end
                    end
                    pkt.delete();
                end
            end
            if (respCycle < 0 && !draining && c == TMO - 1) begin
                if (pkt.size() != 0) begin
                    draining = 1;
                end else begin
                    respCycle = TMO; eErr = 1'b1; eTmo = 1'b1; eRd = 16'h0000;
                end
            end
        end
    endtask

    // Presents one command and waits (bounded) for it to be accepted
    task automatic applyStimulus(input logic wr, input logic [15:0] dest, input logic [15:0] addr,
                                 input logic [15:0] wdata, output bit ok);
        int guard;
        @(negedge clk);
        req_write = wr;
        req_dest  = dest;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = req_ready;
        if (!ok) begin
            checkOutput("reqAccept", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble the command inputs; the latched copy must be used
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_dest  = 16'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
    endtask

    task automatic runTxn(input logic wr, input logic [15:0] dest, input logic [15:0] addr,
                          input logic [15:0] wdata, input int readyMode);
        logic [15:0] exp [5];
        int          n, idx, guard, respCycle;
        logic        v, r, eErr, eTmo;
        logic [15:0] eRd;
        bit          ok;
        exp[0] = dest;
        exp[1] = {6'b0, id};
        exp[2] = wr ? 16'h1000 : 16'h0000;
        exp[3] = addr;
        exp[4] = wdata;
        n = wr ? 5 : 4;
        applyStimulus(wr, dest, addr, wdata, ok);
        if (!ok) return;

        idx = 0;
        guard = 0;
        while (idx < n && guard < 200) begin
            @(negedge clk);
            case (readyMode)
                0:       r = 1'b1;
                1:       r = ((guard % 2) == 1);
                default: r = 1'($urandom);
            endcase
            debug_out_ready = r;
            v = debug_out.valid;
            checkOutput("outValid", 32'(v), 32'd1);
            checkOutput("outData", 32'(debug_out.data), 32'(exp[idx]));
            checkOutput("outLast", 32'(debug_out.last), 32'(idx == n - 1));
            checkOutput("reqReadyBusy", 32'(req_ready), 32'd0);
            @(posedge clk);
            if (v && r) idx++;
            guard++;
        end
        if (idx < n) begin
            checkOutput("sendDone", 32'(idx), 32'(n));
            return;
        end

        predict(wr, dest, respCycle, eErr, eTmo, eRd);
        for (int c = 0; c <= respCycle; c++) begin
            @(negedge clk);
            if (c < respCycle && c < SCH_MAX && schValid[c]) begin
                debug_in.valid = 1'b1;
                debug_in.data  = schData[c];
                debug_in.last  = schLast[c];
            end else begin
                debug_in = '0;
            end
            checkOutput("respValid", 32'(resp_valid), 32'(c == respCycle));
            if (c < respCycle) begin
                checkOutput("inReady", 32'(debug_in_ready), 32'd1);
            end else begin
                checkOutput("respErr", 32'(resp_err), 32'(eErr));
                checkOutput("respTimeout", 32'(resp_timeout), 32'(eTmo));
                checkOutput("respRdata", 32'(resp_rdata), 32'(eRd));
                checkOutput("outIdle", 32'(debug_out.valid), 32'd0);
            end
        end
        @(negedge clk);
        debug_in = '0;
        checkOutput("respPulse", 32'(resp_valid), 32'd0);
        checkOutput("reqReadyAgain", 32'(req_ready), 32'd1);
    endtask

    // Reset pulled while the third request flit is on the bus
    task automatic resetMidSend();
        bit ok;
        applyStimulus(1'b1, 16'h0003, 16'h0300, 16'h5555, ok);
        if (!ok) return;
        debug_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstMidFlit", 32'(debug_out.data), 32'h0000_1000);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstOutValid", 32'(debug_out.valid), 32'd0);
        checkOutput("rstRespValid", 32'(resp_valid), 32'd0);
        checkOutput("rstReqReady", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("postRstRespValid", 32'(resp_valid), 32'd0);
        checkOutput("postRstReqReady", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        wr;
        logic [15:0] dest;
        id              = 10'h005;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_dest        = 16'h0000;
        req_addr        = 16'h0000;
        req_wdata       = 16'h0000;
        debug_in        = '0;
        debug_out_ready = 1'b0;
        rst             = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReqReady", 32'(req_ready), 32'd0);
        checkOutput("rstOutValid", 32'(debug_out.valid), 32'd0);
        checkOutput("rstRespValid", 32'(resp_valid), 32'd0);
        checkOutput("rstRespErr", 32'(resp_err), 32'd0);
        checkOutput("rstRespTimeout", 32'(resp_timeout), 32'd0);
        checkOutput("rstRespRdata", 32'(resp_rdata), 32'd0);
        checkOutput("rstInReady", 32'(debug_in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterRst", 32'(req_ready), 32'd1);

        // Read success
        clearSched();
        addFlit(0, 16'h0005, 1'b0);
        addFlit(0, 16'h0003, 1'b0);
        addFlit(0, 16'h2000, 1'b0);
        addFlit(0, 16'h0040, 1'b1);
        runTxn(1'b0, 16'h0003, 16'h0200, 16'h0000, 0);

        // Write error under toggling backpressure
        clearSched();
        addPacket(1, 1'b1, 16'h0003, 0);
        runTxn(1'b1, 16'h0003, 16'h0201, 16'hBEEF, 1);

        // Foreign packet before the real response
        clearSched();
        addPacket(2, 1'b0, 16'h0003, 0);
        addPacket(0, 1'b0, 16'h0003, 0);
        runTxn(1'b0, 16'h0003, 16'h0010, 16'h0000, 0);

        // Plain timeout
        clearSched();
        runTxn(1'b0, 16'h0003, 16'h0020, 16'h0000, 0);

        // Timeout with a packet straddling expiry
        clearSched();
        addFlit(13, 16'h0005, 1'b0);
        addFlit(0, 16'h0003, 1'b0);
        addFlit(0, 16'h2000, 1'b0);
        addFlit(0, 16'h1234, 1'b1);
        runTxn(1'b0, 16'h0003, 16'h0030, 16'h0000, 0);

        // Reset in the middle of a request, then a normal command
        resetMidSend();
        clearSched();
        addPacket(0, 1'b1, 16'h0003, 0);
        runTxn(1'b1, 16'h0003, 16'h0040, 16'hCAFE, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            id   = 10'($urandom);
            wr   = 1'($urandom);
            dest = 16'($urandom);
            clearSched();
            for (int p = 0; p < int'($urandom_range(3, 1)); p++) begin
                addPacket(int'($urandom_range(5, 0)), wr, dest, int'($urandom_range(2, 0)));
            end
            runTxn(wr, dest, 16'($urandom), 16'($urandom), int'($urandom_range(2, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
